// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   state_t : frame controller state encoding (IDLE..DONE)
//   PS_8    : oversampling ratio 8
//   PS_16   : oversampling ratio 16
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [4:0] PS_8  = 5'd8;
    localparam logic [4:0] PS_16 = 5'd16;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter for the UART frame controller.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   enable    : advance the edge counter (frame in progress)
//   clear     : synchronous clear of both counters (wins over enable)
//   ps        : latched oversampling ratio
//   edge_cnt  : edge index within the current bit, 0..ps-1
//   bit_cnt   : number of completed bits since the last clear
//   bit_end   : edge_cnt is at the last edge of the bit
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int BIT_CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [$bits(PS_16)-1:0]   ps,
    output logic [3:0]                edge_cnt,
    output logic [BIT_CNT_W-1:0]      bit_cnt,
    output logic                      bit_end
);

    assign bit_end = ({1'b0, edge_cnt} == (ps - 5'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                edge_cnt <= edge_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, bit timing, LSB-first
// deserialisation, parity and stop checking, one-cycle result pulses.
// Optional build macro: UART_RX_ERR_CNT_EN enables the saturating error
// counter on err_cnt; without it err_cnt is constant 0.
// Ports:
//   clk, rst        : oversampling clock, asynchronous active-low reset
//   RX_IN           : synchronised serial line, idle high
//   Prescale        : oversampling ratio (8 or 16), latched at frame start
//   PAR_EN, PAR_TYP : parity present / odd parity
//   sampled_bit     : majority-voted bit from data_sampling
//   dat_samp_en     : data_sampling enable
//   edge_cnt        : edge index within the current bit
//   P_DATA          : last good byte
//   data_valid      : P_DATA updated this cycle
//   par_err, stp_err, strt_glitch : one-cycle error pulses
//   err_cnt         : saturating error count
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low
// START  | timing the start bit
// DATA   | shifting in DATA_WIDTH data bits
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit
// DONE   | one cycle; results registered on exit
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [3:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic [7:0]            err_cnt
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    state_t                state, next_state;
    logic [4:0]            ps_lat;
    logic                  par_en_lat;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_mis;
    logic                  stop_bad;
    logic [BCW-1:0]        bit_cnt;
    logic                  bit_end;
    logic                  cnt_clear;

    assign dat_samp_en = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);

    // Clearing on the START bit end gives DATA a fresh bit count.
    assign cnt_clear = !dat_samp_en || ((state == START) && bit_end);

    uart_rx_edge_bit_cnt #(
        .BIT_CNT_W (BCW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (dat_samp_en),
        .clear    (cnt_clear),
        .ps       (ps_lat),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (bit_end) next_state = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_end && (bit_cnt == LAST_BIT))
                         next_state = par_en_lat ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_lat      <= PS_8;
            par_en_lat  <= 1'b0;
            shift_reg   <= '0;
            par_mis     <= 1'b0;
            stop_bad    <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        // Anything other than 16 runs at 8 so the bit timer
                        // always has a sane period.
                        ps_lat     <= (Prescale == PS_16) ? PS_16 : PS_8;
                        par_en_lat <= PAR_EN;
                        par_mis    <= 1'b0;
                        stop_bad   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end && sampled_bit) strt_glitch <= 1'b1;
                end
                DATA: begin
                    if (bit_end) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                end
                PARITY: begin
                    if (bit_end) par_mis <= sampled_bit ^ (^shift_reg) ^ PAR_TYP;
                end
                STOP: begin
                    if (bit_end) stop_bad <= ~sampled_bit;
                end
                DONE: begin
                    par_err <= par_mis & par_en_lat;
                    stp_err <= stop_bad;
                    if (!(par_mis & par_en_lat) && !stop_bad) begin
                        P_DATA     <= shift_reg;
                        data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 8'd0;
        end else if ((par_err || stp_err || strt_glitch) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [4:0] Prescale = 5'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       dat_samp_en;
    logic [3:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, strt_glitch;
    logic [7:0] err_cnt;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One entry per frame sent: timing plus the outcome the line contents imply.
    typedef struct {
        int         s;      // cycle count at which the frame is first in START
        int         nb;     // bits on the line including start and stop
        int         ps;
        bit         gl;
        bit         pe;
        bit         se;
        logic [7:0] data;
    } frame_t;

    frame_t     fq[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_pdata = 8'd0;
    int         m_err = 0;
    bit         err_pend = 1'b0;
    int         dv_count = 0, pe_count = 0, se_count = 0, gl_count = 0;
    int         last_dv_cyc = -1;
    int         last_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        fq.delete();
        m_pdata = 8'd0;
        m_err = 0;
        err_pend = 1'b0;
        #1;
        chk("rst_data_valid", data_valid, 0);
        chk("rst_par_err", par_err, 0);
        chk("rst_stp_err", stp_err, 0);
        chk("rst_strt_glitch", strt_glitch, 0);
        chk("rst_dat_samp_en", dat_samp_en, 0);
        chk("rst_edge_cnt", edge_cnt, 0);
        chk("rst_p_data", P_DATA, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int ps, input bit pen,
                              input bit ptyp, input bit parbit, input bit stopbit,
                              input int abort_at, input bit chg, input bit b2b);
        logic [11:0] bits;
        frame_t      f;
        int          nb;
        nb = pen ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        if (pen) bits[9] = parbit;
        bits[nb - 1] = stopbit;
        Prescale = 5'(ps);
        PAR_EN = pen;
        PAR_TYP = ptyp;
        if (!b2b) @(negedge clk);
        RX_IN = 1'b0;
        sampled_bit = 1'b0;
        f.s = cyc + 1;
        f.nb = nb;
        f.ps = ps;
        f.gl = 1'b0;
        f.data = data;
        f.pe = pen && (parbit != ((^data) ^ ptyp));
        f.se = !stopbit;
        fq.push_back(f);
        last_s = f.s;
        for (int k = 1; k < nb; k++) begin
            wait_cyc(f.s + k * ps);
            RX_IN = bits[k];
            sampled_bit = bits[k];
            if (chg && k == 4) begin
                Prescale = (ps == 16) ? 5'd8 : 5'd16;
                PAR_EN = !pen;
            end
            if (k == abort_at) begin
                wait_cyc(f.s + k * ps + ps / 2);
                do_reset();
                return;
            end
        end
        wait_cyc(f.s + nb * ps);
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        wait_cyc(f.s + nb * ps + 1);
    endtask

    task automatic send_glitch(input int ps);
        frame_t f;
        Prescale = 5'(ps);
        @(negedge clk);
        RX_IN = 1'b0;
        sampled_bit = 1'b1;
        f.s = cyc + 1;
        f.nb = 1;
        f.ps = ps;
        f.gl = 1'b1;
        f.pe = 1'b0;
        f.se = 1'b0;
        f.data = 8'd0;
        fq.push_back(f);
        wait_cyc(f.s + 2);
        RX_IN = 1'b1;
        wait_cyc(f.s + ps + 1);
    endtask

    always @(negedge clk) begin
        if (data_valid) begin dv_count++; last_dv_cyc = cyc; end
        if (par_err) pe_count++;
        if (stp_err) se_count++;
        if (strt_glitch) gl_count++;
    end

    always @(negedge clk) begin : compare
        frame_t     f;
        logic       e_dv, e_pe, e_se, e_gl, e_ds;
        logic [3:0] e_edge;
        int         ev, wend;
        e_dv = 0; e_pe = 0; e_se = 0; e_gl = 0; e_ds = 0; e_edge = 0;
        if (err_pend) begin
            if (m_err < 255) m_err++;
            err_pend = 1'b0;
        end
        if (rst && fq.size() > 0) begin
            f = fq[0];
            wend = f.gl ? f.s + f.ps : f.s + f.nb * f.ps;
            ev = f.gl ? f.s + f.ps : f.s + f.nb * f.ps + 1;
            if (cyc >= f.s && cyc < wend) begin
                e_ds = 1'b1;
                e_edge = 4'((cyc - f.s) % f.ps);
            end
            if (cyc == ev) begin
                if (f.gl) e_gl = 1'b1;
                else begin
                    e_pe = f.pe;
                    e_se = f.se;
                    if (!f.pe && !f.se) begin
                        e_dv = 1'b1;
                        m_pdata = f.data;
                    end
                end
                if (e_gl || e_pe || e_se) err_pend = 1'b1;
                void'(fq.pop_front());
            end
        end
        if (rst) begin
            chk("data_valid", data_valid, e_dv);
            chk("par_err", par_err, e_pe);
            chk("stp_err", stp_err, e_se);
            chk("strt_glitch", strt_glitch, e_gl);
            chk("dat_samp_en", dat_samp_en, e_ds);
            chk("edge_cnt", edge_cnt, e_edge);
            chk("p_data", P_DATA, m_pdata);
`ifdef UART_RX_ERR_CNT_EN
            chk("err_cnt", err_cnt, m_err);
`else
            chk("err_cnt", err_cnt, 0);
`endif
        end
    end

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #1;
        rst = 1'b0;
        #2;
        chk("init_p_data", P_DATA, 0);
        chk("init_data_valid", data_valid, 0);
        chk("init_dat_samp_en", dat_samp_en, 0);
        chk("init_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, PS=8, no parity
        send_frame(8'hA5, 8, 0, 0, 0, 1, -1, 0, 0);
        @(negedge clk);
        chk("a5_p_data", P_DATA, 8'hA5);
        chk("a5_dv_count", dv_count, 1);
        chk("a5_latency", last_dv_cyc - (last_s - 1), 82);

        // 0x3C, PS=16, even parity correct; Prescale/PAR_EN wiggled mid-frame
        send_frame(8'h3C, 16, 1, 0, 0, 1, -1, 1, 0);
        @(negedge clk);
        chk("3c_p_data", P_DATA, 8'h3C);
        chk("3c_dv_count", dv_count, 2);
        chk("3c_pe_count", pe_count, 0);

        // 0x3C, PS=8, odd parity with wrong parity bit
        send_frame(8'h3C, 8, 1, 1, 0, 1, -1, 0, 0);
        @(negedge clk);
        chk("par_pe_count", pe_count, 1);
        chk("par_dv_count", dv_count, 2);
        chk("par_p_data_held", P_DATA, 8'h3C);

        // 0x81 bad stop, then back-to-back good 0x55
        send_frame(8'h81, 8, 0, 0, 0, 0, -1, 0, 0);
        send_frame(8'h55, 8, 0, 0, 0, 1, -1, 0, 1);
        @(negedge clk);
        chk("stop_se_count", se_count, 1);
        chk("b2b_p_data", P_DATA, 8'h55);
        chk("b2b_dv_count", dv_count, 3);

        // start glitch, PS=16
        send_glitch(16);
        @(negedge clk);
        chk("glitch_count", gl_count, 1);
        chk("glitch_dv_count", dv_count, 3);
        chk("glitch_idle", dat_samp_en, 0);
`ifndef UART_RX_ERR_CNT_EN
        chk("err_cnt_off", err_cnt, 0);
`endif

        // reset during data bit 4, then clean 0xF0
        send_frame(8'hF0, 8, 0, 0, 0, 1, 5, 0, 0);
        repeat (2) @(negedge clk);
        send_frame(8'hF0, 8, 0, 0, 0, 1, -1, 0, 0);
        @(negedge clk);
        chk("f0_p_data", P_DATA, 8'hF0);
        chk("f0_dv_count", dv_count, 4);

`ifdef UART_RX_ERR_CNT_EN
        chk("errcnt_zero", err_cnt, 0);
        send_glitch(16);
        @(negedge clk);
        chk("errcnt_1", err_cnt, 1);
        send_frame(8'h81, 8, 0, 0, 0, 0, -1, 0, 0);
        @(negedge clk);
        chk("errcnt_2", err_cnt, 2);
        send_frame(8'h3C, 8, 1, 1, 0, 1, -1, 0, 0);
        @(negedge clk);
        chk("errcnt_3", err_cnt, 3);
        for (int i = 0; i < 297; i++) send_glitch(8);
        @(negedge clk);
        chk("errcnt_sat", err_cnt, 255);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
